// File: rtl/parity_frame_rx.sv
// Serial receiver for the 4-bit parity-framed link: start, 4 data bits LSB first,
// parity, stop. Delivers the word with reduction flags through a valid/ack holding register.
module parity_frame_rx #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       sdi,
    input  logic       rx_ack,
    output logic [3:0] rx_data,
    output logic       rx_valid,
    output logic       all_ones,
    output logic       any_one,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state;
    logic [3:0] shift_reg;
    logic [1:0] bit_cnt;
    logic       par_bit;
    logic       par_mismatch;
    logic       can_load;

    // Odd parity expects the XNOR of the data, so the mismatch flips with ODD_PARITY.
    assign par_mismatch = par_bit ^ (^shift_reg) ^ ODD_PARITY;
    assign can_load     = !rx_valid || rx_ack;

    // Frame FSM and holding register; a load in the stop cycle takes precedence over an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= 4'b0000;
            bit_cnt    <= 2'd0;
            par_bit    <= 1'b0;
            rx_data    <= 4'b0000;
            rx_valid   <= 1'b0;
            all_ones   <= 1'b0;
            any_one    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!sdi) begin
                            state   <= DATA;
                            bit_cnt <= 2'd0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg[bit_cnt] <= sdi;
                        bit_cnt            <= bit_cnt + 2'd1;
                        if (bit_cnt == 2'd3) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= sdi;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (sdi) begin
                            if (can_load) begin
                                rx_data    <= shift_reg;
                                all_ones   <= &shift_reg;
                                any_one    <= |shift_reg;
                                parity_err <= par_mismatch;
                                rx_valid   <= 1'b1;
                                overrun    <= 1'b0;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: an even- and an odd-parity receiver share
// one serial line and are compared against a frame-level reference model.
module tb_parity_frame_rx;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       sdi;
    logic       rx_ack;

    logic [3:0] e_rx_data,   o_rx_data;
    logic       e_rx_valid,  o_rx_valid;
    logic       e_all_ones,  o_all_ones;
    logic       e_any_one,   o_any_one;
    logic       e_parity_err, o_parity_err;
    logic       e_frame_err, o_frame_err;
    logic       e_overrun,   o_overrun;
    logic       e_busy,      o_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state, updated once per frame or ack.
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_perr_even;
    logic       m_perr_odd;
    logic       m_ovr;
    logic       m_ferr;
    logic       m_busy;

    parity_frame_rx #(.ODD_PARITY(1'b0)) dut_even (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sdi        (sdi),
        .rx_ack     (rx_ack),
        .rx_data    (e_rx_data),
        .rx_valid   (e_rx_valid),
        .all_ones   (e_all_ones),
        .any_one    (e_any_one),
        .parity_err (e_parity_err),
        .frame_err  (e_frame_err),
        .overrun    (e_overrun),
        .busy       (e_busy)
    );

    parity_frame_rx #(.ODD_PARITY(1'b1)) dut_odd (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sdi        (sdi),
        .rx_ack     (rx_ack),
        .rx_data    (o_rx_data),
        .rx_valid   (o_rx_valid),
        .all_ones   (o_all_ones),
        .any_one    (o_any_one),
        .parity_err (o_parity_err),
        .frame_err  (o_frame_err),
        .overrun    (o_overrun),
        .busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " even.rx_data"},    e_rx_data,             m_data);
        checkValue({tag, " even.rx_valid"},   {3'b000, e_rx_valid},  {3'b000, m_valid});
        checkValue({tag, " even.all_ones"},   {3'b000, e_all_ones},  {3'b000, &m_data});
        checkValue({tag, " even.any_one"},    {3'b000, e_any_one},   {3'b000, |m_data});
        checkValue({tag, " even.parity_err"}, {3'b000, e_parity_err}, {3'b000, m_perr_even});
        checkValue({tag, " even.frame_err"},  {3'b000, e_frame_err}, {3'b000, m_ferr});
        checkValue({tag, " even.overrun"},    {3'b000, e_overrun},   {3'b000, m_ovr});
        checkValue({tag, " even.busy"},       {3'b000, e_busy},      {3'b000, m_busy});
        checkValue({tag, " odd.rx_data"},     o_rx_data,             m_data);
        checkValue({tag, " odd.rx_valid"},    {3'b000, o_rx_valid},  {3'b000, m_valid});
        checkValue({tag, " odd.parity_err"},  {3'b000, o_parity_err}, {3'b000, m_perr_odd});
        checkValue({tag, " odd.frame_err"},   {3'b000, o_frame_err}, {3'b000, m_ferr});
        checkValue({tag, " odd.overrun"},     {3'b000, o_overrun},   {3'b000, m_ovr});
        checkValue({tag, " odd.busy"},        {3'b000, o_busy},      {3'b000, m_busy});
    endtask

    task automatic modelReset();
        m_data      = 4'h0;
        m_valid     = 1'b0;
        m_perr_even = 1'b0;
        m_perr_odd  = 1'b0;
        m_ovr       = 1'b0;
        m_ferr      = 1'b0;
        m_busy      = 1'b0;
    endtask

    task automatic doReset();
        rst    = 1'b1;
        bit_en = 1'b0;
        rx_ack = 1'b0;
        sdi    = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
    endtask

    task automatic sendBit(input logic b, input logic ack, input int gap);
        sdi    = b;
        bit_en = 1'b1;
        rx_ack = ack;
        tick();
        bit_en = 1'b0;
        rx_ack = 1'b0;
        sdi    = 1'b1;
    endtask

    // One complete frame; the model is updated from the word-level outcome at the stop sample.
    task automatic applyStimulus(input string tag, input logic [3:0] data, input logic par,
                                 input logic stop, input logic ack_at_stop, input int gap);
        logic [6:0] frame_bits;
        int ones;
        frame_bits = {stop, par, data, 1'b0};
        ones = $countones(data);
        for (int i = 0; i < 7; i++) begin
            sendBit(frame_bits[i], (i == 6) ? ack_at_stop : 1'b0, gap);
            if (i == 0) begin
                m_busy = 1'b1;
                checkOutput({tag, " start"});
            end
            if (i == 6) begin
                m_busy = 1'b0;
                if (stop) begin
                    if (!m_valid || ack_at_stop) begin
                        m_data      = data;
                        m_valid     = 1'b1;
                        m_perr_even = (par != ((ones % 2) == 1));
                        m_perr_odd  = (par != ((ones % 2) == 0));
                        m_ovr       = 1'b0;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                    if (ack_at_stop && m_valid) begin
                        m_valid     = 1'b0;
                        m_perr_even = 1'b0;
                        m_perr_odd  = 1'b0;
                        m_ovr       = 1'b0;
                    end
                end
                checkOutput({tag, " stop"});
                m_ferr = 1'b0;
            end
            repeat (gap) tick();
        end
    endtask

    task automatic ackWord(input string tag);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid     = 1'b0;
            m_perr_even = 1'b0;
            m_perr_odd  = 1'b0;
            m_ovr       = 1'b0;
        end
        checkOutput(tag);
    endtask

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        sdi    = 1'b1;
        rx_ack = 1'b0;
        modelReset();
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset");

        // Word 4'b1011 with correct even parity, then ack.
        applyStimulus("b_even", 4'b1011, 1'b1, 1'b1, 1'b0, 3);
        ackWord("b_ack");

        // All-ones word with a wrong even parity bit.
        applyStimulus("f_perr", 4'hF, 1'b1, 1'b1, 1'b0, 3);
        ackWord("f_ack");

        // Stop bit low: frame error pulse, nothing delivered.
        applyStimulus("bad_stop", 4'h0, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("bad_stop_after");

        // Second good frame without ack overruns.
        applyStimulus("ovr_3", 4'h3, 1'b0, 1'b1, 1'b0, 3);
        applyStimulus("ovr_5", 4'h5, 1'b0, 1'b1, 1'b0, 3);
        ackWord("ovr_ack");

        // Ack coinciding with the second stop sample loads the new word.
        applyStimulus("sim_3", 4'h3, 1'b0, 1'b1, 1'b0, 3);
        applyStimulus("sim_5", 4'h5, 1'b0, 1'b1, 1'b1, 3);
        ackWord("sim_ack");

        // Reset in the middle of a frame, then a clean 4'hA frame.
        sendBit(1'b0, 1'b0, 0);
        repeat (3) tick();
        sendBit(1'b1, 1'b0, 0);
        repeat (3) tick();
        sendBit(1'b1, 1'b0, 0);
        m_busy = 1'b1;
        checkOutput("mid_frame");
        doReset();
        checkOutput("mid_reset");
        applyStimulus("a_even", 4'hA, 1'b0, 1'b1, 1'b0, 3);
        ackWord("a_ack");
        applyStimulus("a_odd", 4'hA, 1'b1, 1'b1, 1'b0, 3);
        ackWord("a_odd_ack");

        // Back-to-back frames with no gap.
        applyStimulus("b2b_1", 4'h6, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus("b2b_2", 4'h9, 1'b1, 1'b1, 1'b1, 0);
        ackWord("b2b_ack");

        // Randomized frames, gaps and acks.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] d;
            logic       p;
            logic       s;
            logic       a;
            d = 4'($urandom_range(0, 15));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 7) != 0);
            a = 1'($urandom_range(0, 1));
            applyStimulus("rand", d, p, s, a, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) begin
                ackWord("rand_ack");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Serial receiver for the 4-bit parity-framed link; the receive-side counterpart to the word-level reduction logic that generates parity and summary flags.
- Deserializes start / 4 data bits LSB first / parity / stop, checks parity and framing, and presents the word plus reduction flags to the consumer.
- Uses a valid/ack holding register with overrun detection.
- Sits between the serial line (already synchronized and bit-strobed upstream) and the 4-bit datapath.

Parameters:
- ODD_PARITY, 0, 0 = even parity: the parity bit equals the XOR of the 4 data bits. 1 = odd parity: the parity bit equals the XNOR of the 4 data bits.

Ports:
- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-high
- bit_en  input  1  one-cycle strobe; sdi is sampled only in cycles where bit_en=1
- sdi  input  1  serial data in; idle level 1
- rx_ack  input  1  consumer acknowledges the held word; meaningful only while rx_valid=1
- rx_data  output  4  received data word, held while rx_valid=1
- rx_valid  output  1  held word available; stays high until acknowledged
- all_ones  output  1  AND-reduction of rx_data, registered with rx_data
- any_one  output  1  OR-reduction of rx_data, registered with rx_data
- parity_err  output  1  the held word failed the parity check
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0
- overrun  output  1  sticky flag: a good frame arrived while the holding register was full
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: when rst=1 at a clock edge, FSM goes to IDLE, the shift register and bit counter clear, and all outputs go to 0. This applies even mid-frame; the partial frame is discarded. rst has priority over every other input.
- FSM states and transitions; each transition occurs only in a cycle with bit_en=1, and the FSM holds its state when bit_en=0:
  - IDLE: sdi=0 moves to DATA and sets cnt=0. sdi=1 stays in IDLE.
  - DATA: shifts sdi into bit position cnt (LSB first) and increments cnt. After the 4th bit (cnt==3) moves to PARITY.
  - PARITY: captures the parity bit, then moves to STOP.
  - STOP: always moves to IDLE.
    - sdi=1 completes a good frame.
    - sdi=0 pulses frame_err for 1 cycle and discards the word. rx_* outputs are unchanged.
- Parity check: a mismatch is computed against the XOR of the 4 data bits, adjusted by ODD_PARITY. A word with a parity mismatch is still delivered, with parity_err=1.
- Delivery on a good frame, in the same clock edge as the STOP sample:
  - If rx_valid=0, or rx_valid=1 and rx_ack=1 in that cycle: load rx_data, all_ones, any_one and parity_err, and set rx_valid=1.
  - If rx_valid=1 and rx_ack=0: drop the new word, keep the held word, and set overrun=1.
- Ack:
  - rx_ack=1 while rx_valid=1 clears rx_valid, parity_err and overrun on the next edge, unless a simultaneous load occurs. In that case rx_valid stays 1, the new values are loaded, and overrun is cleared.
  - rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises on the clock edge that samples the stop bit, i.e. it is visible 1 cycle after the stop-bit strobe cycle.
- Back-to-back frames: a start bit may be sampled on the bit_en immediately after the stop bit; there is no idle gap requirement.
- all_ones and any_one are registered copies of the AND and OR reductions of the loaded word; they never change while rx_valid=1 without an ack.
- Glitch start: there is no false-start rejection. A single 0 sample in IDLE starts a frame; if that frame's stop bit is sampled as 0, frame_err is reported.

Test Plan:
- Even parity (ODD_PARITY=0), one bit_en every 4 clocks, bit sequence 0,1,1,0,1,1,1 -> rx_data=4'b1011, rx_valid=1, parity_err=0, all_ones=0, any_one=1; rx_ack clears rx_valid 1 cycle later.
- Data 4'b1111 sent with parity bit 1 under even parity -> rx_data=4'hF, all_ones=1, parity_err=1.
- Stop bit sampled as 0 (frame 0,0,0,0,0,0,0) -> frame_err 1-cycle pulse, rx_valid stays 0, FSM returns to IDLE (busy=0).
- Two good frames 4'h3 then 4'h5 with no ack -> rx_data stays 4'h3, overrun=1; then ack -> rx_valid=0, overrun=0.
- Ack asserted in the same cycle as the second frame's stop sample -> rx_data=4'h5, rx_valid stays 1, overrun=0.
- rst=1 after 2 data bits, then a full frame for 4'hA (0,0,1,0,1,0,1 even) -> rx_data=4'hA with no residue from the aborted frame. Also sweep ODD_PARITY=1 with 4'hA and parity bit 1 -> parity_err=0.
